mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port.
- Arbitrates between the two requesters and sequences each access through a fixed MEM_LAT-cycle memory latency.
- Returns read data, and generates a stall for the pipeline hazard logic.
- Sits between the pipelined MIPS core and the memory model inside top.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter_lat_counter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing for the IF/DM unified-memory port arbiter.
// Imported by the interface, the latency counter and the arbiter top.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side request ports and the memory-side bus of the arbiter.
// slave = arbiter view; master = core plus memory model view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter with zero flag; times the MEM_LAT window of a BUSY access.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: default assigned first so no path through this block leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and DM ports onto one single-port memory with a fixed MEM_LAT access time.
// Define MEM_PORT_ARB_RR_EN for round-robin on simultaneous requests; default is fixed DM priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 2
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    gnt_e              win;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              cnt_load, cnt_dec, cnt_zero;

`ifdef MEM_PORT_ARB_RR_EN
    gnt_e last_gnt_q, last_gnt_d;
`endif

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // DM is the older instruction, so it wins ties unless round-robin is built in.
    always_comb begin
        win = GNT_DM;
`ifdef MEM_PORT_ARB_RR_EN
        if (bus.if_req && bus.dm_req) begin
            win = (last_gnt_q == GNT_DM) ? GNT_IF : GNT_DM;
        end else if (bus.if_req) begin
            win = GNT_IF;
        end
`else
        if (bus.if_req && !bus.dm_req) begin
            win = GNT_IF;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
        last_gnt_d  = last_gnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d  = BUSY;
                    gnt_d    = win;
                    mem_en_d = 1'b1;
                    cnt_load = 1'b1;
`ifdef MEM_PORT_ARB_RR_EN
                    last_gnt_d = win;
`endif
                    if (win == GNT_DM) begin
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                    end
                end
            end

            BUSY: begin
                if (cnt_zero) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = bus.mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        // Stores leave the load-data register untouched.
                        if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                        dm_ready_d = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

`ifdef MEM_PORT_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt_q <= GNT_IF;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: MEM_LAT=2 instance with a transaction-level
// reference model plus a MEM_LAT=1 instance for back-to-back fetch timing.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT  = 2;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk (clk), .reset (reset), .bus (bus)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1)) dut1 (
        .clk (clk), .reset (reset), .bus (bus1)
    );

    // Memory environment: data only valid after the address has been held MEM_LAT cycles.
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        mem_load = 1'b0;
    int          held;

    always @(posedge clk) begin
        if (mem_load) mem <= ref_mem;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) held <= 0;
        else if (bus.mem_en) held <= held + 1;
        else held <= 0;
    end

    assign bus.mem_rdata  = (bus.mem_en && (held + 1 >= LAT)) ? mem[bus.mem_addr[9:2]] : 'x;
    assign bus1.mem_rdata = bus1.mem_en ? mem[bus1.mem_addr[9:2]] : 'x;

    // Reference model state (transaction level).
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          idle_at = 0;
    bit          active = 0;
    int          t_start;
    gnt_e        t_port;
    logic [31:0] t_addr, t_wdata;
    bit          t_we;
    gnt_e        last_gnt = GNT_IF;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;
    bit          seen_if_rdy, seen_dm_rdy;
    int          last_if_rdy_cyc, last_dm_rdy_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: arbitrate in the model, compare every DUT output, advance.
    task automatic step();
        bit en_exp, rdy, rdy_if, rdy_dm;
        @(negedge clk);
        if (cyc >= idle_at && (bus.if_req || bus.dm_req)) begin
            if (bus.if_req && bus.dm_req) begin
`ifdef MEM_PORT_ARB_RR_EN
                t_port = (last_gnt == GNT_IF) ? GNT_DM : GNT_IF;
`else
                t_port = GNT_DM;
`endif
            end else begin
                t_port = bus.dm_req ? GNT_DM : GNT_IF;
            end
            last_gnt = t_port;
            t_start  = cyc;
            idle_at  = cyc + LAT + 2;
            active   = 1;
            t_addr   = (t_port == GNT_DM) ? bus.dm_addr : bus.if_addr;
            t_we     = (t_port == GNT_DM) && bus.dm_we;
            t_wdata  = bus.dm_wdata;
        end
        en_exp = active && (cyc > t_start) && (cyc <= t_start + LAT);
        rdy    = active && (cyc == t_start + LAT + 1);
        rdy_if = rdy && (t_port == GNT_IF);
        rdy_dm = rdy && (t_port == GNT_DM);
        if (rdy) begin
            if (t_we) ref_mem[t_addr[9:2]] = t_wdata;
            else if (t_port == GNT_IF) exp_if_rdata = ref_mem[t_addr[9:2]];
            else exp_dm_rdata = ref_mem[t_addr[9:2]];
        end
        check("mem_en", bus.mem_en, en_exp);
        check("mem_we", bus.mem_we, en_exp && t_we);
        if (en_exp) check("mem_addr", bus.mem_addr, t_addr);
        if (en_exp && t_we) check("mem_wdata", bus.mem_wdata, t_wdata);
        check("if_ready", bus.if_ready, rdy_if);
        check("dm_ready", bus.dm_ready, rdy_dm);
        check("if_rdata", bus.if_rdata, exp_if_rdata);
        check("dm_rdata", bus.dm_rdata, exp_dm_rdata);
        check("stall", bus.stall, (bus.if_req && !rdy_if) || (bus.dm_req && !rdy_dm));
        seen_if_rdy = bus.if_ready;
        seen_dm_rdy = bus.dm_ready;
        if (seen_if_rdy) last_if_rdy_cyc = cyc;
        if (seen_dm_rdy) last_dm_rdy_cyc = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Issue one request on one port and run until its ready pulse (bounded).
    task automatic single(input bit dm, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        int  start;
        bit  done;
        start = cyc;
        done  = 0;
        if (dm) begin
            bus.dm_req = 1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
        end else begin
            bus.if_req = 1; bus.if_addr = addr;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (dm ? seen_dm_rdy : seen_if_rdy) done = 1;
        end
        bus.if_req = 0;
        bus.dm_req = 0;
        check({tag, "_done"}, 32'(done), 32'd1);
        if (done) check({tag, "_lat"}, 32'((dm ? last_dm_rdy_cyc : last_if_rdy_cyc) - start),
                        32'(LAT + 1));
    endtask

    initial begin
        gnt_e        order[$];
        gnt_e        exp_order[4];
        int          r1[$];
        logic [31:0] d1[$];
        bit          got, both_if, both_dm, drop_seen;

        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.dm_req = 0; bus1.dm_we = 0;
        bus1.dm_addr = '0; bus1.dm_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h2002_0005;
        mem_load = 1;

        #1 reset = 0;
        #50 mem_load = 0;
        #40;
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_if_ready", bus.if_ready, 0);
        check("rst_dm_ready", bus.dm_ready, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_dm_rdata", bus.dm_rdata, 0);
        check("rst_stall", bus.stall, 0);
        #11 reset = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step();

        // IF read of word 0, then DM store 7 to 84 and read-back.
        single(0, 0, 32'h0, 32'h0, "if_rd0");
        check("if_rdata_word0", bus.if_rdata, 32'h2002_0005);
        single(1, 1, 32'd84, 32'd7, "dm_st84");
        single(1, 0, 32'd84, 32'h0, "dm_ld84");
        check("dm_rdata_84", bus.dm_rdata, 32'd7);

        // Simultaneous IF 0x04 / DM load 80.
        bus.if_req = 1; bus.if_addr = 32'h4;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'd80;
        both_if = 0; both_dm = 0;
        for (int i = 0; i < 30 && !(both_if && both_dm); i++) begin
            step();
            if (seen_dm_rdy) begin both_dm = 1; bus.dm_req = 0; end
            if (seen_if_rdy) begin both_if = 1; bus.if_req = 0; end
        end
        check("simul_done", 32'(both_if && both_dm), 32'd1);
        check("simul_gap", 32'(last_if_rdy_cyc - last_dm_rdy_cyc), 32'(LAT + 2));

        // Both requests held for four transactions.
        bus.if_req = 1; bus.if_addr = 32'h10;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h20;
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            step();
            if (seen_dm_rdy) order.push_back(GNT_DM);
            if (seen_if_rdy) order.push_back(GNT_IF);
        end
`ifdef MEM_PORT_ARB_RR_EN
        exp_order = '{GNT_DM, GNT_IF, GNT_DM, GNT_IF};
`else
        exp_order = '{GNT_DM, GNT_DM, GNT_DM, GNT_DM};
`endif
        check("hold_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            check($sformatf("hold_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        bus.dm_req = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (seen_if_rdy) got = 1;
        end
        bus.if_req = 0;
        check("hold_if_served", 32'(got), 32'd1);

        // Requester drops dm_req right after grant; access must still complete.
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h8;
        step();
        bus.dm_req = 0;
        drop_seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            if (seen_dm_rdy) drop_seen = 1;
        end
        check("drop_ready", 32'(drop_seen), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step();
            if (seen_if_rdy) bus.if_req = 0;
            if (seen_dm_rdy) bus.dm_req = 0;
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1; bus.if_addr = $urandom;
            end
            if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
                bus.dm_req = 1; bus.dm_we = 1'($urandom_range(0, 1));
                bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
            end
        end
        for (int i = 0; i < 60 && (bus.if_req || bus.dm_req); i++) begin
            step();
            if (seen_if_rdy) bus.if_req = 0;
            if (seen_dm_rdy) bus.dm_req = 0;
        end
        check("drain", 32'(bus.if_req || bus.dm_req), 32'd0);
        step();

        // Reset asserted mid-BUSY: immediate clear, no ready afterwards.
        bus.if_req = 1; bus.if_addr = 32'h0;
        step();
        step();
        check("busy_before_rst", bus.mem_en, 1);
        #2 reset = 0;
        #1;
        check("async_rst_mem_en", bus.mem_en, 0);
        check("async_rst_mem_addr", bus.mem_addr, 0);
        check("async_rst_if_rdata", bus.if_rdata, 0);
        bus.if_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_if_ready", bus.if_ready, 0);
        end
        @(posedge clk); #1 reset = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_if_ready", bus.if_ready, 0);
            check("post_rst_dm_ready", bus.dm_ready, 0);
            check("post_rst_mem_en", bus.mem_en, 0);
        end
        @(posedge clk); #1;
        active = 0; idle_at = cyc; last_gnt = GNT_IF;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        single(0, 0, 32'h4, 32'h0, "if_rd_after_rst");

        // MEM_LAT=1 instance: back-to-back fetches of 0x00 and 0x04.
        bus1.if_req = 1; bus1.if_addr = 32'h0;
        for (int i = 0; i < 20 && r1.size() < 2; i++) begin
            @(negedge clk);
            got = bus1.if_ready;
            if (got) begin r1.push_back(i); d1.push_back(bus1.if_rdata); end
            @(posedge clk); #1;
            if (got && r1.size() == 1) bus1.if_addr = 32'h4;
            if (got && r1.size() == 2) bus1.if_req = 0;
        end
        check("lat1_count", 32'(r1.size()), 32'd2);
        if (r1.size() == 2) begin
            check("lat1_first", 32'(r1[0]), 32'(LAT1 + 1));
            check("lat1_gap", 32'(r1[1] - r1[0]), 32'(LAT1 + 2));
            check("lat1_data0", d1[0], ref_mem[0]);
            check("lat1_data1", d1[1], ref_mem[1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
